lvt_mem_nw_nr: RTL and testbench

//  Multi-port register-file memory: NW write ports, NR read ports, single clock edge.

---
 rtl/lvt_mem_nw_nr.sv | 78 +++++++
 tb/tb_lvt_mem_nw_nr.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_mem_nw_nr.sv
// Multi-port register file: NW write ports, NR read ports, built from NW*NR 1w1r banks plus
// a Live Value Table. Optional write-to-read forwarding when LVT_BYPASS_EN is defined.
module lvt_mem_nw_nr #(
  parameter int NW = 2,
  parameter int NR = 4,
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] write_addr,
  input  logic [NW*DW-1:0] write_data,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] read_addr,
  output logic [NR*DW-1:0] read_data,
  output logic [NR-1:0]    read_valid
);

  localparam int DEPTH = 1 << AW;
  localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

  logic [DW-1:0]    bank [NW][NR][DEPTH];
  logic [LW-1:0]    lvt  [DEPTH];
  logic [NR*DW-1:0] rd_next;
  logic [AW-1:0]    ra;

  // Bank storage is deliberately not reset; writes are suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      for (int w = 0; w < NW; w++) begin
        for (int r = 0; r < NR; r++) begin
          if (we[w]) bank[w][r][write_addr[w*AW +: AW]] <= write_data[w*DW +: DW];
        end
      end
    end
  end

  // Ascending loop: the last nonblocking update wins, so the highest-index writer owns the entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < DEPTH; a++) lvt[a] <= '0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (we[w]) lvt[write_addr[w*AW +: AW]] <= LW'(w);
      end
    end
  end

  always_comb begin
    rd_next = '0;
    ra      = '0;
    for (int r = 0; r < NR; r++) begin
      ra = read_addr[r*AW +: AW];
      rd_next[r*DW +: DW] = bank[lvt[ra]][r][ra];
`ifdef LVT_BYPASS_EN
      for (int w = 0; w < NW; w++) begin
        if (we[w] && (write_addr[w*AW +: AW] == ra)) rd_next[r*DW +: DW] = write_data[w*DW +: DW];
      end
`endif
    end
  end

  // read_valid is a one-cycle strobe with no ready: the consumer must take read_data
  // in the cycle read_valid[r] is high; read_data holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data  <= '0;
      read_valid <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        read_valid[r] <= re[r];
        if (re[r]) read_data[r*DW +: DW] <= rd_next[r*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_lvt_mem_nw_nr.sv
// Self-checking bench for lvt_mem_nw_nr: directed scenarios then random traffic against
// an array-based model of the register file (honours LVT_BYPASS_EN).
module tb_lvt_mem_nw_nr;

  localparam int NW = 2;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic             clock;
  logic             reset_n;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] write_addr;
  logic [NW*DW-1:0] write_data;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] read_addr;
  logic [NR*DW-1:0] read_data;
  logic [NR-1:0]    read_valid;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: one logical word per (writer, address), plus last-writer table
  logic [DW-1:0] m_bank  [NW][DEPTH];
  bit            m_known [NW][DEPTH];
  int            m_lvt   [DEPTH];
  logic [DW-1:0] e_rd [NR];
  bit            e_kn [NR];
  logic [NR-1:0] e_v;

  lvt_mem_nw_nr #(.NW(NW), .NR(NR), .DW(DW), .AW(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .we         (we),
    .write_addr (write_addr),
    .write_data (write_data),
    .re         (re),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_valid (read_valid)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) m_lvt[a] = 0;
    for (int r = 0; r < NR; r++) begin
      e_rd[r] = '0;
      e_kn[r] = 1'b1;
    end
    e_v = '0;
  endtask

  task automatic idle();
    we = '0; write_addr = '0; write_data = '0; re = '0; read_addr = '0;
  endtask

  task automatic drv_write(input int w, input int addr, input logic [DW-1:0] data);
    we[w] = 1'b1;
    write_addr[w*AW +: AW] = AW'(addr);
    write_data[w*DW +: DW] = data;
  endtask

  task automatic drv_read(input int r, input int addr);
    re[r] = 1'b1;
    read_addr[r*AW +: AW] = AW'(addr);
  endtask

  // One clock: predict from pre-edge model, update model, then compare #1 after the edge.
  task automatic cycle();
    logic [DW-1:0] nd;
    bit nk;
    int a;
    if (reset_n) begin
      for (int r = 0; r < NR; r++) begin
        if (re[r]) begin
          a  = int'(read_addr[r*AW +: AW]);
          nd = m_bank[m_lvt[a]][a];
          nk = m_known[m_lvt[a]][a];
`ifdef LVT_BYPASS_EN
          for (int w = 0; w < NW; w++) begin
            if (we[w] && int'(write_addr[w*AW +: AW]) == a) begin
              nd = write_data[w*DW +: DW];
              nk = 1'b1;
            end
          end
`endif
          e_rd[r] = nd;
          e_kn[r] = nk;
          e_v[r]  = 1'b1;
        end else begin
          e_v[r] = 1'b0;
        end
      end
      for (int w = 0; w < NW; w++) begin
        if (we[w]) begin
          a = int'(write_addr[w*AW +: AW]);
          m_bank[w][a]  = write_data[w*DW +: DW];
          m_known[w][a] = 1'b1;
          m_lvt[a]      = w;
        end
      end
    end else begin
      model_reset();
    end
    @(posedge clock);
    #1;
    check("read_valid", DW'(read_valid), DW'(e_v));
    for (int r = 0; r < NR; r++) begin
      if (e_kn[r]) check($sformatf("read_data%0d", r), read_data[r*DW +: DW], e_rd[r]);
    end
  endtask

  initial begin
    for (int w = 0; w < NW; w++)
      for (int a = 0; a < DEPTH; a++) begin
        m_bank[w][a]  = '0;
        m_known[w][a] = 1'b0;
      end
    idle();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_valid", DW'(read_valid), '0);
    for (int r = 0; r < NR; r++) check("reset_data", read_data[r*DW +: DW], '0);
    #2 reset_n = 1'b1;

    // single port write, then all readers
    drv_write(0, 3, 32'hDEAD_BEEF);
    cycle();
    idle();
    for (int r = 0; r < NR; r++) drv_read(r, 3);
    cycle();
    check("t2_valid", DW'(read_valid), 32'hF);
    for (int r = 0; r < NR; r++) check("t2_data", read_data[r*DW +: DW], 32'hDEAD_BEEF);

    // write conflict: higher-index port wins
    idle();
    drv_write(0, 5, 32'h1111_1111);
    drv_write(1, 5, 32'h2222_2222);
    cycle();
    idle();
    drv_read(0, 5);
    drv_read(2, 5);
    cycle();
    check("t3_conflict_r0", read_data[0 +: DW], 32'h2222_2222);
    check("t3_conflict_r2", read_data[2*DW +: DW], 32'h2222_2222);

    // port interleave: LVT moves back to bank 0
    idle();
    drv_write(1, 7, 32'hA5);
    cycle();
    idle();
    drv_write(0, 7, 32'h5A);
    cycle();
    idle();
    drv_read(1, 7);
    cycle();
    check("t4_interleave", read_data[DW +: DW], 32'h5A);

    // same-cycle read of a written address
    idle();
    drv_write(0, 9, 32'h0);
    cycle();
    idle();
    drv_write(0, 9, 32'h99);
    drv_read(1, 9);
    cycle();
`ifdef LVT_BYPASS_EN
    check("t5_same_cycle", read_data[DW +: DW], 32'h99);
`else
    check("t5_same_cycle", read_data[DW +: DW], 32'h0);
`endif

    // hold: re=0 keeps data, drops valid
    idle();
    cycle();
    check("hold_data", read_data[DW +: DW], 32'h99 & {DW{1'b1}}
`ifndef LVT_BYPASS_EN
      & 32'h0
`endif
    );

    // reset mid-traffic, held across an edge with pending writes
    idle();
    drv_write(0, 3, 32'hCAFE_0000);
    drv_write(1, 3, 32'hCAFE_0001);
    for (int r = 0; r < NR; r++) drv_read(r, 3);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_valid", DW'(read_valid), '0);
    for (int r = 0; r < NR; r++) check("midreset_data", read_data[r*DW +: DW], '0);
    cycle();
    #2 reset_n = 1'b1;
    idle();
    drv_read(0, 3);
    drv_read(1, 5);
    drv_read(2, 7);
    cycle();
    check("post_reset_a3", read_data[0 +: DW], 32'hDEAD_BEEF);
    check("post_reset_a5", read_data[DW +: DW], 32'h1111_1111);
    check("post_reset_a7", read_data[2*DW +: DW], 32'h5A);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      idle();
      for (int w = 0; w < NW; w++)
        if ($urandom_range(0, 1) == 1) drv_write(w, $urandom_range(0, DEPTH-1), DW'($urandom));
      for (int r = 0; r < NR; r++)
        if ($urandom_range(0, 3) != 0) drv_read(r, $urandom_range(0, DEPTH-1));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
